// File: rtl/nand_op_sequencer_pkg.sv
// Shared definitions for the NAND op sequencer: host op codes, NAND command
// bytes, cmd_kind encodings, FSM states and small decode helpers.
package nand_op_sequencer_pkg;

  // Host op codes (5-7 are illegal)
  localparam logic [2:0] OP_RESET   = 3'd0;
  localparam logic [2:0] OP_READ    = 3'd1;
  localparam logic [2:0] OP_PROGRAM = 3'd2;
  localparam logic [2:0] OP_ERASE   = 3'd3;
  localparam logic [2:0] OP_STATUS  = 3'd4;

  // NAND command bytes
  localparam logic [7:0] NAND_RESET   = 8'hFF;
  localparam logic [7:0] NAND_READ1   = 8'h00;
  localparam logic [7:0] NAND_READ2   = 8'h30;
  localparam logic [7:0] NAND_PROG1   = 8'h80;
  localparam logic [7:0] NAND_PROG2   = 8'h10;
  localparam logic [7:0] NAND_ERASE1  = 8'h60;
  localparam logic [7:0] NAND_ERASE2  = 8'hD0;
  localparam logic [7:0] NAND_STATUS  = 8'h70;

  // cmd_kind encodings (2 and 3 reserved)
  localparam logic [1:0] KIND_CLE = 2'd0;
  localparam logic [1:0] KIND_ALE = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD1   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_XFER   = 3'd3,
    ST_CMD2   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_BUSY   = 3'd6,
    ST_DONE   = 3'd7
  } seq_state_t;

  function automatic logic op_legal(input logic [2:0] code);
    return (code <= OP_STATUS);
  endfunction

  // First command byte of each op
  function automatic logic [7:0] first_cmd(input logic [2:0] code);
    logic [7:0] b;
    case (code)
      OP_RESET:   b = NAND_RESET;
      OP_READ:    b = NAND_READ1;
      OP_PROGRAM: b = NAND_PROG1;
      OP_ERASE:   b = NAND_ERASE1;
      OP_STATUS:  b = NAND_STATUS;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

  // Closing command byte for the ops that have one
  function automatic logic [7:0] second_cmd(input logic [2:0] code);
    logic [7:0] b;
    case (code)
      OP_READ:    b = NAND_READ2;
      OP_PROGRAM: b = NAND_PROG2;
      OP_ERASE:   b = NAND_ERASE2;
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nand_op_sequencer_busy_timer.sv
// Loadable down-counter shared by the SETTLE and BUSY phases. expired is high
// during the last cycle of a loaded interval, so a load of N marks the Nth
// cycle after the load edge.
module nand_op_sequencer_busy_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clock_100,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clock_100 or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/nand_op_sequencer.sv
// Turns one host flash op into the ordered NAND command/address byte stream
// for cmd_queue, paces it on the selected die's R/B, hands data phases to the
// datapath and reports done/err per op. All outputs are registered.
//
// Handshakes: op is accepted on a clock edge where op_valid & op_ready.
// cmd_valid is held with stable cmd_byte/cmd_kind/cmd_ce until an edge where
// cmd_ready is high; that edge transfers the byte and the next byte (if any)
// is presented in the following cycle. cmd_ready may stall indefinitely.
module nand_op_sequencer
  import nand_op_sequencer_pkg::*;
#(
  parameter int unsigned COL_BYTES    = 2,
  parameter int unsigned ROW_BYTES    = 3,
  parameter int unsigned SETTLE_CYC   = 10,
  parameter int unsigned BUSY_TIMEOUT = 1000000
) (
  input  logic        clock_100,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic        op_target,
  input  logic [15:0] op_col,
  input  logic [23:0] op_row,
  output logic [7:0]  cmd_byte,
  output logic [1:0]  cmd_kind,
  output logic        cmd_ce,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic        rb1_ctrl,
  input  logic        rb2_ctrl,
  output logic        data_go,
  input  logic        data_done,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

  seq_state_t  state, state_n;
  logic [2:0]  op_code_q;
  logic [15:0] col_q;
  logic [23:0] row_q;
  logic [2:0]  addr_cnt, addr_cnt_n;
  logic [2:0]  last_idx;
  logic        accept;
  logic        rb_sel;
  logic        op_ready_n, cmd_valid_n, data_go_n, done_n, err_n;
  logic [7:0]  cmd_byte_n;
  logic [1:0]  cmd_kind_n;
  logic        timer_load;
  logic [TW-1:0] timer_val;
  logic        timer_expired;

  // Address byte idx of the current op: column bytes first, then row bytes,
  // each LSB first. ERASE sends the row only.
  function automatic logic [7:0] addr_byte(input logic [2:0]  code,
                                           input logic [15:0] col,
                                           input logic [23:0] row,
                                           input logic [2:0]  idx);
    logic [2:0] ridx;
    logic [7:0] b;
    ridx = idx;
    if (code != OP_ERASE && idx < 3'(COL_BYTES)) begin
      b = 8'(col >> {idx, 3'b000});
    end else begin
      if (code != OP_ERASE) ridx = idx - 3'(COL_BYTES);
      b = 8'(row >> {ridx, 3'b000});
    end
    return b;
  endfunction

  assign last_idx  = (op_code_q == OP_ERASE) ? 3'(ROW_BYTES - 1)
                                             : 3'(COL_BYTES + ROW_BYTES - 1);
  // cmd_ce holds the latched die select, so it picks the R/B to watch
  assign rb_sel    = cmd_ce ? rb2_ctrl : rb1_ctrl;
  assign state_dbg = state;

  nand_op_sequencer_busy_timer #(.W(TW)) u_timer (
    .clock_100 (clock_100),
    .rst       (rst),
    .load      (timer_load),
    .load_val  (timer_val),
    .expired   (timer_expired)
  );

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    op_ready_n  = 1'b0;
    cmd_valid_n = cmd_valid;
    cmd_byte_n  = cmd_byte;
    cmd_kind_n  = cmd_kind;
    data_go_n   = 1'b0;
    done_n      = 1'b0;
    err_n       = 1'b0;
    addr_cnt_n  = addr_cnt;
    timer_load  = 1'b0;
    timer_val   = '0;
    accept      = 1'b0;
    case (state)
      ST_IDLE: begin
        op_ready_n = 1'b1;
        if (op_valid && op_ready) begin
          accept     = 1'b1;
          op_ready_n = 1'b0;
          if (!op_legal(op_code)) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n     = ST_CMD1;
            cmd_valid_n = 1'b1;
            cmd_kind_n  = KIND_CLE;
            cmd_byte_n  = first_cmd(op_code);
            addr_cnt_n  = '0;
          end
        end
      end
      ST_CMD1: begin
        if (cmd_ready) begin
          case (op_code_q)
            OP_RESET: begin
              cmd_valid_n = 1'b0;
              state_n     = ST_SETTLE;
              timer_load  = 1'b1;
              timer_val   = TW'(SETTLE_CYC);
            end
            OP_STATUS: begin
              cmd_valid_n = 1'b0;
              state_n     = ST_XFER;
              data_go_n   = 1'b1;
            end
            default: begin
              state_n    = ST_ADDR;
              cmd_kind_n = KIND_ALE;
              cmd_byte_n = addr_byte(op_code_q, col_q, row_q, 3'd0);
              addr_cnt_n = '0;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (cmd_ready) begin
          if (addr_cnt == last_idx) begin
            if (op_code_q == OP_PROGRAM) begin
              // Write data goes out before the confirm command
              cmd_valid_n = 1'b0;
              state_n     = ST_XFER;
              data_go_n   = 1'b1;
            end else begin
              state_n    = ST_CMD2;
              cmd_kind_n = KIND_CLE;
              cmd_byte_n = second_cmd(op_code_q);
            end
          end else begin
            addr_cnt_n = addr_cnt + 3'd1;
            cmd_byte_n = addr_byte(op_code_q, col_q, row_q, addr_cnt + 3'd1);
          end
        end
      end
      ST_XFER: begin
        if (data_done) begin
          if (op_code_q == OP_PROGRAM) begin
            state_n     = ST_CMD2;
            cmd_valid_n = 1'b1;
            cmd_kind_n  = KIND_CLE;
            cmd_byte_n  = NAND_PROG2;
          end else begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end
      end
      ST_CMD2: begin
        if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          state_n     = ST_SETTLE;
          timer_load  = 1'b1;
          timer_val   = TW'(SETTLE_CYC);
        end
      end
      ST_SETTLE: begin
        // R/B is not trustworthy until tWB has elapsed
        if (timer_expired) begin
          state_n    = ST_BUSY;
          timer_load = 1'b1;
          timer_val  = TW'(BUSY_TIMEOUT);
        end
      end
      ST_BUSY: begin
        // Ready wins over the timeout in the limit cycle
        if (rb_sel) begin
          if (op_code_q == OP_READ) begin
            state_n   = ST_XFER;
            data_go_n = 1'b1;
          end else begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end
        end else if (timer_expired) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end
      end
      ST_DONE: begin
        state_n    = ST_IDLE;
        op_ready_n = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock_100 or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_byte  <= '0;
      cmd_kind  <= '0;
      data_go   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_cnt  <= '0;
    end else begin
      state     <= state_n;
      op_ready  <= op_ready_n;
      cmd_valid <= cmd_valid_n;
      cmd_byte  <= cmd_byte_n;
      cmd_kind  <= cmd_kind_n;
      data_go   <= data_go_n;
      done      <= done_n;
      err       <= err_n;
      addr_cnt  <= addr_cnt_n;
    end
  end

  // Capture the op fields on accept
  always_ff @(posedge clock_100 or negedge rst) begin
    if (!rst) begin
      op_code_q <= '0;
      cmd_ce    <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else if (accept) begin
      op_code_q <= op_code;
      cmd_ce    <= op_target;
      col_q     <= op_col;
      row_q     <= op_row;
    end
  end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Directed bench for nand_op_sequencer with a byte scoreboard, an automatic
// data-phase responder and cycle-exact latency checks on the R/B paths.
module tb_nand_op_sequencer;

  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic        clock_100 = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic        op_target = 1'b0;
  logic [15:0] op_col = 16'h0;
  logic [23:0] op_row = 24'h0;
  logic [7:0]  cmd_byte;
  logic [1:0]  cmd_kind;
  logic        cmd_ce;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        rb1_ctrl = 1'b0;
  logic        rb2_ctrl = 1'b0;
  logic        data_go;
  logic        data_done = 1'b0;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  always #5 clock_100 = ~clock_100;

  nand_op_sequencer #(
    .COL_BYTES    (2),
    .ROW_BYTES    (3),
    .SETTLE_CYC   (SETTLE),
    .BUSY_TIMEOUT (TIMEOUT)
  ) dut (
    .clock_100 (clock_100),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_target (op_target),
    .op_col    (op_col),
    .op_row    (op_row),
    .cmd_byte  (cmd_byte),
    .cmd_kind  (cmd_kind),
    .cmd_ce    (cmd_ce),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rb1_ctrl  (rb1_ctrl),
    .rb2_ctrl  (rb2_ctrl),
    .data_go   (data_go),
    .data_done (data_done),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clock_100) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int          xfer_cnt = 0;
  int          valid_cycles = 0;
  int          last_xfer_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [10:0] stall_val = '0;
  logic        xfer_pending = 1'b0;

  task automatic expect_byte(input logic ce, input logic [1:0] kind, input logic [7:0] b);
    exp_q.push_back({ce, kind, b});
  endtask

  // Byte monitor: hold stability under stall, in-order compare on transfer
  always @(negedge clock_100) begin
    logic [10:0] got;
    logic [10:0] want;
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (cmd_valid) valid_cycles++;
      if (stall_prev)
        check("cmd_hold", {21'd0, cmd_valid, cmd_ce, cmd_kind, cmd_byte}, {21'd0, 1'b1, stall_val});
      if (cmd_valid && cmd_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc + 1;
        check("byte_during_xfer", xfer_pending, 0);
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          got  = {cmd_ce, cmd_kind, cmd_byte};
          want = exp_q.pop_front();
          check("cmd_stream", got, want);
        end
      end
      stall_prev = cmd_valid && !cmd_ready;
      stall_val  = {cmd_ce, cmd_kind, cmd_byte};
    end
  end

  // done/err monitor
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic done_err = 1'b0;
  always @(negedge clock_100) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end else if (err) begin
      check("err_without_done", err, 0);
    end
  end

  // Data-phase responder: answers each data_go with a data_done pulse
  int go_cnt = 0;
  int go_sb_left = 0;
  always begin
    @(negedge clock_100);
    if (data_go) begin
      go_cnt++;
      go_sb_left = exp_q.size();
      xfer_pending = 1'b1;
      repeat (4) @(posedge clock_100);
      #1 data_done = 1'b1;
      @(posedge clock_100);
      #1 data_done = 1'b0;
      xfer_pending = 1'b0;
    end
  end

  // cmd_ready pattern: 0 = always ready, 1 = toggle every cycle
  int rdy_mode = 0;
  always @(posedge clock_100) begin
    #1;
    if (rdy_mode == 1) cmd_ready = ~cmd_ready;
    else cmd_ready = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_100);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic tgt,
                       input logic [15:0] col, input logic [23:0] row);
    op_code   = code;
    op_target = tgt;
    op_col    = col;
    op_row    = row;
    op_valid  = 1'b1;
    @(negedge clock_100);
    check("op_ready_before_accept", op_ready, 1);
    tick();
    op_valid = 1'b0;
    @(negedge clock_100);
    check("op_ready_after_accept", op_ready, 0);
  endtask

  task automatic wait_xfers(input string tag, input int target, input int budget);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(negedge clock_100);
      n++;
    end
    check({tag, "_xfers"}, xfer_cnt >= target, 1);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    do begin
      tick();
      n++;
    end while (cyc < target && n < 1000);
  endtask

  task automatic wait_done(input string tag, input int budget, input int base_cnt);
    int n = 0;
    while (done_cnt == base_cnt && n < budget) begin
      @(negedge clock_100);
      n++;
    end
    check({tag, "_done_seen"}, done_cnt != base_cnt, 1);
    repeat (3) @(negedge clock_100);
    check({tag, "_done_single"}, done_cnt, base_cnt + 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int x0;
    int g0;
    int v0;

    // Reset state
    repeat (3) @(negedge clock_100);
    check("reset_outputs", {16'd0, op_ready, cmd_valid, cmd_byte, cmd_kind, cmd_ce, data_go, done, err}, 0);
    tick();
    rst = 1'b1;
    @(negedge clock_100);
    check("op_ready_low_before_first_edge", op_ready, 0);
    @(negedge clock_100);
    check("op_ready_after_release", op_ready, 1);

    // 1: RESET to die 0, unselected die ready, rb1 high 50 cycles after FF
    tick();
    rb1_ctrl = 1'b0;
    rb2_ctrl = 1'b1;
    base = done_cnt;
    x0 = xfer_cnt;
    expect_byte(1'b0, 2'd0, 8'hFF);
    issue(3'd0, 1'b0, 16'h0, 24'h0);
    wait_xfers("reset", x0 + 1, 20);
    wait_cyc(last_xfer_cyc + 49);
    rb1_ctrl = 1'b1;
    wait_done("reset", 100, base);
    check("reset_latency", done_cyc - last_xfer_cyc, 50);
    check("reset_err", done_err, 0);

    // 2: READ die 1, unselected die ready while selected stays busy
    tick();
    rb2_ctrl = 1'b0;
    base = done_cnt;
    x0 = xfer_cnt;
    g0 = go_cnt;
    expect_byte(1'b1, 2'd0, 8'h00);
    expect_byte(1'b1, 2'd1, 8'h23);
    expect_byte(1'b1, 2'd1, 8'h01);
    expect_byte(1'b1, 2'd1, 8'h78);
    expect_byte(1'b1, 2'd1, 8'h56);
    expect_byte(1'b1, 2'd1, 8'h04);
    expect_byte(1'b1, 2'd0, 8'h30);
    issue(3'd1, 1'b1, 16'h0123, 24'h045678);
    wait_xfers("read", x0 + 7, 50);
    repeat (30) tick();
    check("read_no_go_while_busy", go_cnt, g0);
    check("read_no_done_while_busy", done_cnt, base);
    rb2_ctrl = 1'b1;
    wait_done("read", 100, base);
    check("read_go_count", go_cnt, g0 + 1);
    check("read_err", done_err, 0);

    // 3: PROGRAM die 0 with cmd_ready toggling
    tick();
    rdy_mode = 1;
    base = done_cnt;
    g0 = go_cnt;
    expect_byte(1'b0, 2'd0, 8'h80);
    expect_byte(1'b0, 2'd1, 8'hEF);
    expect_byte(1'b0, 2'd1, 8'hBE);
    expect_byte(1'b0, 2'd1, 8'hE1);
    expect_byte(1'b0, 2'd1, 8'hC3);
    expect_byte(1'b0, 2'd1, 8'hA5);
    expect_byte(1'b0, 2'd0, 8'h10);
    issue(3'd2, 1'b0, 16'hBEEF, 24'hA5C3E1);
    wait_done("program", 300, base);
    check("program_go_count", go_cnt, g0 + 1);
    check("program_go_after_addr", go_sb_left, 1);
    check("program_err", done_err, 0);
    tick();
    rdy_mode = 0;
    tick();

    // 4a: ERASE die 0, R/B stuck low -> timeout exactly at the limit
    rb1_ctrl = 1'b0;
    base = done_cnt;
    expect_byte(1'b0, 2'd0, 8'h60);
    expect_byte(1'b0, 2'd1, 8'hDE);
    expect_byte(1'b0, 2'd1, 8'hBC);
    expect_byte(1'b0, 2'd1, 8'h9A);
    expect_byte(1'b0, 2'd0, 8'hD0);
    issue(3'd3, 1'b0, 16'hFFFF, 24'h9ABCDE);
    wait_done("erase_timeout", 300, base);
    check("erase_timeout_latency", done_cyc - last_xfer_cyc, SETTLE + TIMEOUT);
    check("erase_timeout_err", done_err, 1);

    // 4b: ERASE, R/B rises in the limit cycle -> ready, no err
    tick();
    base = done_cnt;
    x0 = xfer_cnt;
    expect_byte(1'b0, 2'd0, 8'h60);
    expect_byte(1'b0, 2'd1, 8'h33);
    expect_byte(1'b0, 2'd1, 8'h22);
    expect_byte(1'b0, 2'd1, 8'h11);
    expect_byte(1'b0, 2'd0, 8'hD0);
    issue(3'd3, 1'b0, 16'h0000, 24'h112233);
    wait_xfers("erase_limit", x0 + 5, 20);
    wait_cyc(last_xfer_cyc + SETTLE + TIMEOUT - 1);
    rb1_ctrl = 1'b1;
    wait_done("erase_limit", 50, base);
    check("erase_limit_latency", done_cyc - last_xfer_cyc, SETTLE + TIMEOUT);
    check("erase_limit_err", done_err, 0);

    // 5: illegal op code
    tick();
    base = done_cnt;
    v0 = valid_cycles;
    issue(3'd6, 1'b0, 16'h0, 24'h0);
    check("illegal_done", done, 1);
    check("illegal_err", err, 1);
    @(negedge clock_100);
    check("illegal_op_ready_back", op_ready, 1);
    check("illegal_done_drop", done, 0);
    repeat (3) @(negedge clock_100);
    check("illegal_done_count", done_cnt, base + 1);
    check("illegal_no_bytes", valid_cycles, v0);

    // 6: reset in the middle of the address phase, then a fresh STATUS
    tick();
    x0 = xfer_cnt;
    expect_byte(1'b0, 2'd0, 8'h00);
    expect_byte(1'b0, 2'd1, 8'h11);
    expect_byte(1'b0, 2'd1, 8'h11);
    expect_byte(1'b0, 2'd1, 8'h22);
    expect_byte(1'b0, 2'd1, 8'h22);
    expect_byte(1'b0, 2'd1, 8'h22);
    expect_byte(1'b0, 2'd0, 8'h30);
    issue(3'd1, 1'b0, 16'h1111, 24'h222222);
    wait_xfers("abort", x0 + 3, 20);
    check("abort_mid_addr_valid", cmd_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_outputs_zero", {16'd0, op_ready, cmd_valid, cmd_byte, cmd_kind, cmd_ce, data_go, done, err}, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) @(negedge clock_100);
    check("abort_op_ready_back", op_ready, 1);
    tick();
    base = done_cnt;
    x0 = xfer_cnt;
    g0 = go_cnt;
    expect_byte(1'b1, 2'd0, 8'h70);
    issue(3'd4, 1'b1, 16'hABCD, 24'h123456);
    wait_done("status", 50, base);
    check("status_byte_count", xfer_cnt, x0 + 1);
    check("status_go_count", go_cnt, g0 + 1);
    check("status_err", done_err, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
